icap_arbiter: RTL and testbench
===============================

# icap_arbiter

Two-port arbiter that shares the single `icap_controller` command/write/read path between two requesters: port 0, the host partial-reconfiguration loader, and port 1, the configuration readback/scrub engine. It grants one requester at a time with round-robin fairness and holds the grant for a whole ICAP transaction, from command accept through `done`. While a grant is held it muxes the 32-bit write and read streams between the granted requester and the controller. It also counts completed transactions per port and flags transactions that exceed a watchdog limit.

## Interface
- `C_TIMEOUT_CYCLES`, default 2^24: watchdog limit, in cycles spent in ACTIVE.
- `C_CNT_WIDTH`, default 16: width of each per-port completion counter.
- `aclk`  in  1  single clock; everything is synchronous to its rising edge.
- `areset`  in  1  synchronous, active-high reset.
- `sN_ctrl_data`  in  icapControl_t  request command from port N, N ∈ {0,1}; fields `size` [26:0] and `rdwrb`.
- `sN_ctrl_valid` in 1 / `sN_ctrl_ready` out 1  request handshake for port N.
- `sN_done`  out  1  one-cycle completion pulse to port N.
- `sN_write_data` in 32 / `sN_write_valid` in 1 / `sN_write_last` in 1 / `sN_write_ready` out 1  write stream from port N.
- `sN_read_data` out 32 / `sN_read_valid` out 1 / `sN_read_last` out 1 / `sN_read_ready` in 1  read stream to port N.
- `m_ctrl_data` out icapControl_t / `m_ctrl_valid` out 1 / `m_ctrl_ready` in 1 / `m_done` in 1  command path to the controller.
- `m_write_*` (outputs, `m_write_ready` input) and `m_read_*` (inputs, `m_read_ready` output)  stream paths to the controller; same widths as the port streams.
- `grant`  out  2  one-hot owner of the current transaction; `2'b00` in IDLE.
- `busy`  out  1  high in ISSUE and ACTIVE.
- `timeout`  out  1  sticky watchdog flag.
- `cnt0`, `cnt1`  out  C_CNT_WIDTH  completed-transaction counters for each port; wrap at full scale.

## Operation
- The state machine has three states: IDLE, ISSUE, ACTIVE.
- **IDLE**
  - Arbitrate among the asserted `sN_ctrl_valid`.
  - If only one port is valid, it wins.
  - If both are valid, the port that was not in `last_grant` wins.
  - The winner sees `sN_ctrl_ready=1` combinationally in the same cycle.
  - On that edge: latch the winner's `ctrl_data` into `cmd_q`, set `grant`, set `last_grant`, go to ISSUE.
  - Losing ports see `ctrl_ready=0`.
- **ISSUE**
  - `m_ctrl_valid=1` and `m_ctrl_data=cmd_q`.
  - When `m_ctrl_ready=1`, go to ACTIVE and clear the watchdog counter.
- **ACTIVE**
  - Forward the granted port's streams combinationally: write valid/data/last to `m_write_*`, `m_write_ready` back to that port, `m_read_*` to that port, and its `read_ready` to `m_read_ready`.
  - The non-granted port sees `write_ready=0`, `read_valid=0`, `read_last=0`, `done=0`, and its `read_data` driven to 0.
  - `sN_done = m_done & grant[N]`.
  - On `m_done`: increment `cntN`, clear `grant`, go to IDLE.
- **Watchdog**
  - The counter increments every ACTIVE cycle and saturates.
  - When it reaches C_TIMEOUT_CYCLES−1, `timeout` is set. It stays set until `areset`.
  - The grant is NOT released on timeout, because the ICAP cannot be aborted mid-transaction.
- **`m_done` outside ACTIVE** is ignored.
- **Reset values:** state=IDLE, `grant=0`, `last_grant=port1` (so port 0 wins the first tie), `busy=0`, `timeout=0`, `cnt0=cnt1=0`, `m_ctrl_valid=0`, all ready/valid/done outputs 0.
- **Reset mid-operation:** return to IDLE immediately, with no `done` pulse. The owning software re-inits the controller as well.

## Timing
- Request accept to `m_ctrl_valid` rising: 1 cycle.
- Stream muxes add zero latency; they are purely combinational on the registered `grant` and state.
- `m_done` to `sN_done`: 0 cycles, combinational.
- `m_done` edge to next possible `sN_ctrl_ready`: 1 cycle (the IDLE cycle).
- Minimum transaction overhead added by the arbiter: 2 cycles (IDLE accept + ISSUE).
- A requester holding `ctrl_valid` high across grants is served at most every other transaction when the other port is also requesting.
- `grant` and `busy` are registered, change only at state transitions, and are glitch-free.
- `cntN` wraps from 2^C_CNT_WIDTH−1 to 0.

## Test plan
- **Single write:** port 0 requests size=4, rdwrb=0 and streams 4 words ending with last; the model asserts `m_done` 2 cycles after last.
  - Required: `m_ctrl_data` matches, `grant=01`, 4 words appear on `m_write_*` unmodified, `s0_done` pulses once, `cnt0=1`, `s1_*` outputs stay 0.
- **Tie and round-robin:** both ports valid from reset with 3 back-to-back requests each.
  - Required: grant order 0,1,0,1,0,1; one IDLE cycle between transactions; `cnt0=cnt1=3`.
- **Readback on port 1:** size=8, rdwrb=1; the model returns 8 words with last on word 8 while port 1 toggles `read_ready` 1/0.
  - Required: data is preserved in order with correct backpressure, `s0_read_valid` stays 0, and port 0 requests during the transfer are held (`ctrl_ready=0`) until after `s1_done`.
- **Watchdog:** C_TIMEOUT_CYCLES=16 and `m_done` withheld.
  - Required: `timeout` rises after 16 ACTIVE cycles and `grant` stays held.
  - A later `m_done` returns the FSM to IDLE with `timeout` still 1.
- **Reset mid-transfer:** assert `areset` during ACTIVE.
  - Required: the next cycle shows `grant=0`, `busy=0`, counters 0, no `sN_done`, and port 0 wins the next tie.
- **Counter wrap:** C_CNT_WIDTH=2 with 5 port-0 transactions.
  - Required: `cnt0` sequence 1,2,3,0,1.

Source files
------------

// File: rtl/icap_arbiter_if.sv
// rtl/icap_arbiter_if.sv - ICAP command/write/read bundle shared by requesters and the controller
// The master drives commands and write data; the slave answers with ready/done and read data.
package icap_arbiter_pkg;
  typedef struct packed {
    logic [26:0] size;
    logic        rdwrb;
  } icap_control_t;
endpackage

interface icap_arbiter_if;
  import icap_arbiter_pkg::*;

  icap_control_t ctrl_data;
  logic          ctrl_valid;
  logic          ctrl_ready;
  logic          done;

  logic [31:0]   write_data;
  logic          write_valid;
  logic          write_last;
  logic          write_ready;

  logic [31:0]   read_data;
  logic          read_valid;
  logic          read_last;
  logic          read_ready;

  modport master (
    output ctrl_data, ctrl_valid, write_data, write_valid, write_last, read_ready,
    input  ctrl_ready, done, write_ready, read_data, read_valid, read_last
  );

  modport slave (
    input  ctrl_data, ctrl_valid, write_data, write_valid, write_last, read_ready,
    output ctrl_ready, done, write_ready, read_data, read_valid, read_last
  );
endinterface

// File: rtl/icap_arbiter.sv
// rtl/icap_arbiter.sv - round-robin two-port arbiter in front of the single ICAP controller
// Grant is held from command accept through m.done; streams are muxed on the registered grant.
module icap_arbiter
  import icap_arbiter_pkg::*;
#(
  parameter int unsigned C_TIMEOUT_CYCLES = 2**24,
  parameter int unsigned C_CNT_WIDTH      = 16
) (
  input  logic                   aclk,
  input  logic                   areset,
  icap_arbiter_if.slave          s0,
  icap_arbiter_if.slave          s1,
  icap_arbiter_if.master         m,
  output logic [1:0]             grant,
  output logic                   busy,
  output logic                   timeout,
  output logic [C_CNT_WIDTH-1:0] cnt0,
  output logic [C_CNT_WIDTH-1:0] cnt1
);

  localparam int unsigned     WD_W     = $clog2(C_TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(C_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_ACTIVE} state_t;

  state_t                 state_q, state_d;
  icap_control_t          cmd_q, cmd_d;
  logic [1:0]             grant_q, grant_d;
  logic                   last_grant_q, last_grant_d;
  logic                   busy_q, busy_d;
  logic                   timeout_q, timeout_d;
  logic [WD_W-1:0]        wd_q, wd_d;
  logic [C_CNT_WIDTH-1:0] cnt0_q, cnt0_d;
  logic [C_CNT_WIDTH-1:0] cnt1_q, cnt1_d;

  logic win0, win1;
  logic act0, act1;

  // last_grant_q is the index of the previous winner; the other port wins a tie
  assign win0 = s0.ctrl_valid & (~s1.ctrl_valid | last_grant_q);
  assign win1 = s1.ctrl_valid & ~win0;

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      grant_q      <= '0;
      last_grant_q <= 1'b1;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      wd_q         <= '0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      wd_q         <= wd_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    timeout_d    = timeout_q;
    wd_d         = wd_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    unique case (state_q)
      ST_IDLE: begin
        if (win0 || win1) begin
          state_d      = ST_ISSUE;
          cmd_d        = win1 ? s1.ctrl_data : s0.ctrl_data;
          grant_d      = {win1, win0};
          last_grant_d = win1;
        end
      end
      ST_ISSUE: begin
        if (m.ctrl_ready) begin
          state_d = ST_ACTIVE;
          wd_d    = '0;
        end
      end
      ST_ACTIVE: begin
        // The ICAP cannot be aborted, so an expired watchdog only raises the flag
        if (wd_q != WD_LIMIT) wd_d = wd_q + 1'b1;
        if (wd_q == WD_LIMIT) timeout_d = 1'b1;
        if (m.done) begin
          state_d = ST_IDLE;
          grant_d = '0;
          if (grant_q[0]) cnt0_d = cnt0_q + 1'b1;
          if (grant_q[1]) cnt1_d = cnt1_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_comb begin
    act0 = (state_q == ST_ACTIVE) & grant_q[0];
    act1 = (state_q == ST_ACTIVE) & grant_q[1];

    s0.ctrl_ready  = (state_q == ST_IDLE) & win0;
    s1.ctrl_ready  = (state_q == ST_IDLE) & win1;
    m.ctrl_valid   = (state_q == ST_ISSUE);
    m.ctrl_data    = cmd_q;

    s0.done        = m.done & act0;
    s1.done        = m.done & act1;

    m.write_data   = act1 ? s1.write_data  : (act0 ? s0.write_data : 32'h0);
    m.write_valid  = (act0 & s0.write_valid) | (act1 & s1.write_valid);
    m.write_last   = (act0 & s0.write_last)  | (act1 & s1.write_last);
    s0.write_ready = act0 & m.write_ready;
    s1.write_ready = act1 & m.write_ready;

    s0.read_data   = act0 ? m.read_data : 32'h0;
    s1.read_data   = act1 ? m.read_data : 32'h0;
    s0.read_valid  = act0 & m.read_valid;
    s1.read_valid  = act1 & m.read_valid;
    s0.read_last   = act0 & m.read_last;
    s1.read_last   = act1 & m.read_last;
    m.read_ready   = (act0 & s0.read_ready) | (act1 & s1.read_ready);

    grant   = grant_q;
    busy    = busy_q;
    timeout = timeout_q;
    cnt0    = cnt0_q;
    cnt1    = cnt1_q;
  end

endmodule

// File: tb/tb_icap_arbiter.sv
// tb/tb_icap_arbiter.sv - directed vector bench for icap_arbiter
// Watchdog limit 16 and 2-bit counters so timeout and wrap are reachable quickly.
module tb_icap_arbiter;
  import icap_arbiter_pkg::*;

  logic       aclk;
  logic       areset;
  logic [1:0] grant;
  logic       busy;
  logic       timeout;
  logic [1:0] cnt0;
  logic [1:0] cnt1;

  icap_arbiter_if s0_if ();
  icap_arbiter_if s1_if ();
  icap_arbiter_if m_if ();

  icap_arbiter #(
    .C_TIMEOUT_CYCLES(16),
    .C_CNT_WIDTH     (2)
  ) dut (
    .aclk   (aclk),
    .areset (areset),
    .s0     (s0_if),
    .s1     (s1_if),
    .m      (m_if),
    .grant  (grant),
    .busy   (busy),
    .timeout(timeout),
    .cnt0   (cnt0),
    .cnt1   (cnt1)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  typedef struct {
    logic          mcr;
    logic          mdone;
    logic [1:0]    grant;
    logic          busy;
    logic          s0r;
    logic          s1r;
    logic          mcv;
    logic          d0;
    logic          d1;
    logic [1:0]    c0;
    logic [1:0]    c1;
    icap_control_t mdata;
  } vec_t;

  localparam icap_control_t CMD_S0 = '{size: 27'h10, rdwrb: 1'b0};
  localparam icap_control_t CMD_S1 = '{size: 27'h20, rdwrb: 1'b1};
  localparam icap_control_t CMD_W4 = '{size: 27'd4,  rdwrb: 1'b0};
  localparam icap_control_t CMD_R8 = '{size: 27'd8,  rdwrb: 1'b1};
  localparam icap_control_t CMD_W5 = '{size: 27'd5,  rdwrb: 1'b0};

  int   n_vec = 0;
  int   n_err = 0;
  vec_t tbl [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    areset = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    areset = 1'b0;
  endtask

  // One complete port-0 transaction; starts and ends on a negedge in IDLE
  task automatic txn0();
    s0_if.ctrl_valid = 1'b1;
    s0_if.ctrl_data  = CMD_S0;
    @(negedge aclk);
    s0_if.ctrl_valid = 1'b0;
    m_if.ctrl_ready  = 1'b1;
    @(negedge aclk);
    m_if.ctrl_ready  = 1'b0;
    m_if.done        = 1'b1;
    @(negedge aclk);
    m_if.done        = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit reached");
    $fatal(1);
  end

  initial begin
    logic [1:0]  wrap_exp [5];
    logic [31:0] word;

    areset = 1'b1;
    s0_if.ctrl_data = '0; s0_if.ctrl_valid = 0; s0_if.write_data = '0; s0_if.write_valid = 0;
    s0_if.write_last = 0; s0_if.read_ready = 0;
    s1_if.ctrl_data = '0; s1_if.ctrl_valid = 0; s1_if.write_data = '0; s1_if.write_valid = 0;
    s1_if.write_last = 0; s1_if.read_ready = 0;
    m_if.ctrl_ready = 0; m_if.done = 0; m_if.write_ready = 0;
    m_if.read_data = '0; m_if.read_valid = 0; m_if.read_last = 0;

    // Round-robin table: three rows (IDLE, ISSUE, ACTIVE+done) per transaction, ports alternate
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < 2; p++) begin
        int b;
        b = (r * 2 + p) * 3;
        tbl[b]   = '{mcr: 0, mdone: 0, grant: 2'b00, busy: 0, s0r: (p == 0), s1r: (p == 1),
                     mcv: 0, d0: 0, d1: 0, c0: 2'(r + p), c1: 2'(r), mdata: '0};
        tbl[b+1] = '{mcr: 1, mdone: 0, grant: (p == 1) ? 2'b10 : 2'b01, busy: 1, s0r: 0, s1r: 0,
                     mcv: 1, d0: 0, d1: 0, c0: 2'(r + p), c1: 2'(r),
                     mdata: (p == 1) ? CMD_S1 : CMD_S0};
        tbl[b+2] = '{mcr: 0, mdone: 1, grant: (p == 1) ? 2'b10 : 2'b01, busy: 1, s0r: 0, s1r: 0,
                     mcv: 0, d0: (p == 0), d1: (p == 1), c0: 2'(r + p), c1: 2'(r), mdata: '0};
      end
    end
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

    // Reset state
    @(negedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_cnt0", cnt0, 0);
    chk("rst_cnt1", cnt1, 0);
    chk("rst_m_ctrl_valid", m_if.ctrl_valid, 0);
    chk("rst_s0_done", s0_if.done, 0);
    chk("rst_s0_write_ready", s0_if.write_ready, 0);
    chk("rst_s1_read_valid", s1_if.read_valid, 0);

    // Single write on port 0; m.done during ISSUE must be ignored
    @(negedge aclk);
    s0_if.ctrl_valid = 1'b1;
    s0_if.ctrl_data  = CMD_W4;
    m_if.read_data   = 32'h1234_5678;
    #1;
    chk("sw_s0_ctrl_ready", s0_if.ctrl_ready, 1);
    chk("sw_s1_ctrl_ready", s1_if.ctrl_ready, 0);
    @(negedge aclk);
    s0_if.ctrl_valid = 1'b0;
    m_if.done        = 1'b1;
    #1;
    chk("sw_m_ctrl_valid", m_if.ctrl_valid, 1);
    chk("sw_m_ctrl_data", {4'b0, m_if.ctrl_data}, {4'b0, CMD_W4});
    chk("sw_grant", grant, 2'b01);
    chk("sw_busy", busy, 1);
    chk("sw_done_in_issue", s0_if.done, 0);
    @(negedge aclk);
    m_if.done       = 1'b0;
    m_if.ctrl_ready = 1'b1;
    #1;
    chk("sw_still_issue", m_if.ctrl_valid, 1);
    @(negedge aclk);
    m_if.ctrl_ready  = 1'b0;
    m_if.write_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i != 0) @(negedge aclk);
      word = 32'hC0DE_0000 + 32'(i * 17);
      s0_if.write_data  = word;
      s0_if.write_valid = 1'b1;
      s0_if.write_last  = (i == 3);
      #1;
      chk("sw_m_write_data", m_if.write_data, word);
      chk("sw_m_write_valid", m_if.write_valid, 1);
      chk("sw_m_write_last", m_if.write_last, (i == 3));
      chk("sw_s0_write_ready", s0_if.write_ready, 1);
      chk("sw_s1_write_ready", s1_if.write_ready, 0);
      chk("sw_s1_read_data", s1_if.read_data, 0);
    end
    @(negedge aclk);
    s0_if.write_valid = 1'b0;
    s0_if.write_last  = 1'b0;
    @(negedge aclk);
    m_if.done = 1'b1;
    #1;
    chk("sw_s0_done", s0_if.done, 1);
    chk("sw_s1_done", s1_if.done, 0);
    @(negedge aclk);
    m_if.done        = 1'b0;
    m_if.write_ready = 1'b0;
    #1;
    chk("sw_s0_done_once", s0_if.done, 0);
    chk("sw_grant_idle", grant, 0);
    chk("sw_busy_idle", busy, 0);
    chk("sw_cnt0", cnt0, 1);
    chk("sw_cnt1", cnt1, 0);

    // Tie and round-robin from reset, table driven
    @(negedge aclk);
    do_reset();
    s0_if.ctrl_valid = 1'b1;
    s0_if.ctrl_data  = CMD_S0;
    s1_if.ctrl_valid = 1'b1;
    s1_if.ctrl_data  = CMD_S1;
    for (int i = 0; i < 18; i++) begin
      m_if.ctrl_ready = tbl[i].mcr;
      m_if.done       = tbl[i].mdone;
      #1;
      chk($sformatf("rr%0d_grant", i), grant, tbl[i].grant);
      chk($sformatf("rr%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("rr%0d_s0_ready", i), s0_if.ctrl_ready, tbl[i].s0r);
      chk($sformatf("rr%0d_s1_ready", i), s1_if.ctrl_ready, tbl[i].s1r);
      chk($sformatf("rr%0d_m_valid", i), m_if.ctrl_valid, tbl[i].mcv);
      chk($sformatf("rr%0d_s0_done", i), s0_if.done, tbl[i].d0);
      chk($sformatf("rr%0d_s1_done", i), s1_if.done, tbl[i].d1);
      chk($sformatf("rr%0d_cnt0", i), cnt0, tbl[i].c0);
      chk($sformatf("rr%0d_cnt1", i), cnt1, tbl[i].c1);
      if (tbl[i].mcv)
        chk($sformatf("rr%0d_m_data", i), {4'b0, m_if.ctrl_data}, {4'b0, tbl[i].mdata});
      @(negedge aclk);
    end
    s0_if.ctrl_valid = 1'b0;
    s1_if.ctrl_valid = 1'b0;
    m_if.ctrl_ready  = 1'b0;
    m_if.done        = 1'b0;
    #1;
    chk("rr_cnt0_final", cnt0, 3);
    chk("rr_cnt1_final", cnt1, 3);

    // Readback on port 1 with read_ready toggling; port 0 request held off
    @(negedge aclk);
    do_reset();
    s1_if.ctrl_valid = 1'b1;
    s1_if.ctrl_data  = CMD_R8;
    #1;
    chk("rb_s1_ctrl_ready", s1_if.ctrl_ready, 1);
    @(negedge aclk);
    s1_if.ctrl_valid = 1'b0;
    s0_if.ctrl_valid = 1'b1;
    s0_if.ctrl_data  = CMD_W5;
    m_if.ctrl_ready  = 1'b1;
    #1;
    chk("rb_m_ctrl_data", {4'b0, m_if.ctrl_data}, {4'b0, CMD_R8});
    chk("rb_grant", grant, 2'b10);
    chk("rb_s0_held_issue", s0_if.ctrl_ready, 0);
    @(negedge aclk);
    m_if.ctrl_ready = 1'b0;
    for (int c = 0; c < 15; c++) begin
      logic rdy;
      int   idx;
      rdy = (c % 2 == 0);
      idx = c / 2;
      word = 32'hA5A5_0000 + 32'(idx);
      m_if.read_valid   = 1'b1;
      m_if.read_data    = word;
      m_if.read_last    = (idx == 7);
      s1_if.read_ready  = rdy;
      #1;
      chk("rb_s1_read_data", s1_if.read_data, word);
      chk("rb_s1_read_valid", s1_if.read_valid, 1);
      chk("rb_s1_read_last", s1_if.read_last, (idx == 7));
      chk("rb_m_read_ready", m_if.read_ready, rdy);
      chk("rb_s0_read_valid", s0_if.read_valid, 0);
      chk("rb_s0_read_data", s0_if.read_data, 0);
      chk("rb_s0_held", s0_if.ctrl_ready, 0);
      @(negedge aclk);
    end
    m_if.read_valid  = 1'b0;
    m_if.read_last   = 1'b0;
    s1_if.read_ready = 1'b0;
    m_if.done        = 1'b1;
    #1;
    chk("rb_s1_done", s1_if.done, 1);
    chk("rb_s0_done", s0_if.done, 0);
    chk("rb_s0_held_done", s0_if.ctrl_ready, 0);
    @(negedge aclk);
    m_if.done = 1'b0;
    #1;
    chk("rb_s0_served_after", s0_if.ctrl_ready, 1);
    chk("rb_cnt1", cnt1, 1);
    chk("rb_grant_idle", grant, 0);
    s0_if.ctrl_valid = 1'b0;

    // Watchdog: m.done withheld past the limit
    @(negedge aclk);
    do_reset();
    s0_if.ctrl_valid = 1'b1;
    s0_if.ctrl_data  = CMD_W4;
    @(negedge aclk);
    s0_if.ctrl_valid = 1'b0;
    m_if.ctrl_ready  = 1'b1;
    @(negedge aclk);
    m_if.ctrl_ready  = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      #1;
      chk($sformatf("wd_timeout_c%0d", k), timeout, (k >= 17));
      chk($sformatf("wd_grant_c%0d", k), grant, 2'b01);
      @(negedge aclk);
    end
    m_if.done = 1'b1;
    #1;
    chk("wd_s0_done", s0_if.done, 1);
    @(negedge aclk);
    m_if.done = 1'b0;
    #1;
    chk("wd_grant_idle", grant, 0);
    chk("wd_busy_idle", busy, 0);
    chk("wd_timeout_sticky", timeout, 1);

    // Reset in the middle of a transaction, after one port-0 completion
    @(negedge aclk);
    do_reset();
    txn0();
    #1;
    chk("rm_cnt0_before", cnt0, 1);
    s0_if.ctrl_valid = 1'b1;
    s0_if.ctrl_data  = CMD_S0;
    @(negedge aclk);
    s0_if.ctrl_valid = 1'b0;
    m_if.ctrl_ready  = 1'b1;
    @(negedge aclk);
    m_if.ctrl_ready  = 1'b0;
    @(negedge aclk);
    areset = 1'b1;
    #1;
    chk("rm_no_done_during", s0_if.done, 0);
    @(negedge aclk);
    areset = 1'b0;
    #1;
    chk("rm_grant", grant, 0);
    chk("rm_busy", busy, 0);
    chk("rm_cnt0", cnt0, 0);
    chk("rm_cnt1", cnt1, 0);
    chk("rm_timeout", timeout, 0);
    chk("rm_s0_done", s0_if.done, 0);
    chk("rm_m_ctrl_valid", m_if.ctrl_valid, 0);
    s0_if.ctrl_valid = 1'b1;
    s1_if.ctrl_valid = 1'b1;
    #1;
    chk("rm_tie_s0_wins", s0_if.ctrl_ready, 1);
    chk("rm_tie_s1_loses", s1_if.ctrl_ready, 0);
    s0_if.ctrl_valid = 1'b0;
    s1_if.ctrl_valid = 1'b0;

    // Counter wrap with 2-bit counters
    @(negedge aclk);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      txn0();
      #1;
      chk($sformatf("wrap_cnt0_%0d", i), cnt0, wrap_exp[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
